// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus_ram responder.
//   - bus_ram_state_t      : responder FSM states
//   - BUS_ERR_DATA         : read data returned for an out-of-range request
//   - BUS_MAX_WAIT_STATES  : largest supported WAIT_STATES value
//   - BUS_LANE_W/BUS_LANES : byte-lane geometry of the 32-bit data word
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACK
    } bus_ram_state_t;

    localparam logic [31:0] BUS_ERR_DATA        = 32'hDEAD_BEEF;
    localparam int unsigned BUS_MAX_WAIT_STATES = 15;
    localparam int unsigned BUS_LANE_W          = 8;
    localparam int unsigned BUS_LANES           = 4;

endpackage

// File: rtl/bus_ram_if.sv
// bus_ram_if: processor memory bus between an initiator (master) and the
// RAM responder (slave).
//   sel_i      request strobe, held until ack is sampled
//   addr_i     byte address
//   we_i       1 = write, 0 = read
//   wr_mask_i  byte-lane write enables
//   data_i     lane-aligned write data
//   data_o     read data, valid in the ack cycle
//   ack_o      one-cycle completion pulse
//   err_o      out-of-range flag, valid in the ack cycle
interface bus_ram_if;

    logic        sel_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  wr_mask_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output sel_i, addr_i, we_i, wr_mask_i, data_i,
        input  data_o, ack_o, err_o
    );

    modport slave (
        input  sel_i, addr_i, we_i, wr_mask_i, data_i,
        output data_o, ack_o, err_o
    );

endinterface

// File: rtl/bus_ram_array.sv
// bus_ram_array: 2**ADDR_WIDTH x 32 storage with per-byte-lane write enables
// and synchronous read-before-write (rdata gets the word as it was before
// the write at the same edge).
//   clk       clock
//   reset_ni  async active-low reset (read register only; contents kept)
//   en        access enable for this edge
//   addr      word index
//   lane_we   per-lane write enables (ignored unless en)
//   wdata     write data
//   rdata     registered read data, holds between accesses
module bus_ram_array
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset_ni,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_LANES-1:0]  lane_we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned b = 0; b < BUS_LANES; b++) begin
        if (lane_we[b]) begin
          mem[addr][b*BUS_LANE_W +: BUS_LANE_W] <= wdata[b*BUS_LANE_W +: BUS_LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_ram.sv
// bus_ram: word-organised RAM responder for the processor memory bus.
// Captures a request in IDLE, optionally waits WAIT_STATES cycles, performs
// one synchronous array access and pulses ack for one cycle.
//   clk       clock (rising edge)
//   reset_ni  async active-low reset
//   bus       bus_ram_if.slave (sel/addr/we/wr_mask/data in, data/ack/err out)
// Parameters: ADDR_WIDTH (word-address bits), WAIT_STATES (0..15), INIT_FILE.
// Build option: define BUS_RAM_RANGE_CHECK_EN to flag addresses whose bits
// above the array are non-zero (no write, data_o = BUS_ERR_DATA, err_o = 1).
module bus_ram
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      reset_ni,
    bus_ram_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    bus_ram_state_t state, state_next;
    logic [3:0]            cnt;
    logic                  capture;
    logic                  access_en;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_we;
    logic [BUS_LANES-1:0]  req_mask;
    logic [31:0]           req_data;
    logic                  req_err;

    logic                  array_en;
    logic [BUS_LANES-1:0]  lane_we;
    logic [31:0]           rd_data;

    // Low address bits are byte offsets; upper bits only matter to the range check.
    logic                  unused_addr;
    assign unused_addr = ^bus.addr_i;

    assign capture = (state == IDLE) && bus.sel_i;

    // Next-state logic
    always_comb begin
        state_next = state;
        access_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sel_i) begin
                    state_next = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                access_en  = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef BUS_RAM_RANGE_CHECK_EN
    logic range_err;
    logic err_q;

    // Any set bit above the word index is outside the array.
    assign range_err = |(bus.addr_i >> (ADDR_WIDTH + 2));
`else
    logic range_err;

    assign range_err = 1'b0;
`endif

    // Request registers: sampled only on the IDLE capture edge.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            req_addr <= '0;
            req_we   <= 1'b0;
            req_mask <= '0;
            req_data <= '0;
            req_err  <= 1'b0;
        end else if (capture) begin
            req_addr <= bus.addr_i[ADDR_WIDTH+1:2];
            req_we   <= bus.we_i;
            req_mask <= bus.wr_mask_i;
            req_data <= bus.data_i;
            req_err  <= range_err;
        end
    end

    assign array_en = access_en && !req_err;
    assign lane_we  = req_we ? req_mask : '0;

    bus_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk      (clk),
        .reset_ni (reset_ni),
        .en       (array_en),
        .addr     (req_addr),
        .lane_we  (lane_we),
        .wdata    (req_data),
        .rdata    (rd_data)
    );

    assign bus.ack_o = (state == ACK);

`ifdef BUS_RAM_RANGE_CHECK_EN
    // err_q follows each ACCESS so the error word persists like normal read
    // data; err_o itself is only asserted alongside ack.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            err_q <= 1'b0;
        end else if (access_en) begin
            err_q <= req_err;
        end
    end

    assign bus.data_o = err_q ? BUS_ERR_DATA : rd_data;
    assign bus.err_o  = bus.ack_o && err_q;
`else
    assign bus.data_o = rd_data;
    assign bus.err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: directed self-checking bench for bus_ram.
// dut0 runs with WAIT_STATES=0, dut3 with WAIT_STATES=3; both ADDR_WIDTH=12.
// Range-check expectations follow BUS_RAM_RANGE_CHECK_EN.
module tb_bus_ram;
    import bus_pkg::*;

    logic clk    = 1'b0;
    logic rst0_n = 1'b0;
    logic rst3_n = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_ram_if bus0();
    bus_ram_if bus3();

    bus_ram #(.ADDR_WIDTH(12), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset_ni(rst0_n), .bus(bus0.slave)
    );

    bus_ram #(.ADDR_WIDTH(12), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
        .clk(clk), .reset_ni(rst3_n), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input int which, input logic s, input logic we,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] wdata);
        if (which == 3) begin
            bus3.sel_i = s; bus3.we_i = we; bus3.addr_i = addr;
            bus3.wr_mask_i = mask; bus3.data_i = wdata;
        end else begin
            bus0.sel_i = s; bus0.we_i = we; bus0.addr_i = addr;
            bus0.wr_mask_i = mask; bus0.data_i = wdata;
        end
    endtask

    function automatic logic ack_of(input int which);
        return (which == 3) ? bus3.ack_o : bus0.ack_o;
    endfunction

    // One transaction started at the current (negedge) time. lat is the cycle
    // index of ack (sel first high in cycle 0), -1 on timeout. width_ok is 1
    // when ack is low again in the following cycle. drop_at >= 1 drops sel and
    // scrambles the request inputs at that cycle.
    task automatic xact(input int which, input logic we, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        input int drop_at, output int lat,
                        output logic [31:0] rdata, output logic err,
                        output logic width_ok);
        int cyc;
        cyc = 0; lat = -1; rdata = '0; err = 1'b0; width_ok = 1'b0;
        drive(which, 1'b1, we, addr, mask, wdata);
        while (cyc < 40 && lat < 0) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == drop_at) drive(which, 1'b0, ~we, 32'hFFFF_FFFC, ~mask, ~wdata);
            if (ack_of(which)) begin
                lat   = cyc;
                rdata = (which == 3) ? bus3.data_o : bus0.data_o;
                err   = (which == 3) ? bus3.err_o : bus0.err_o;
                drive(which, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        drive(which, 1'b0, 1'b0, '0, '0, '0);
        if (lat >= 0) begin
            @(posedge clk);
            @(negedge clk);
            width_ok = !ack_of(which);
        end
    endtask

    task automatic test_reset();
        logic [33:0] obs0, obs3;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        rst0_n = 1'b0; rst3_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1; rst3_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs0 = {bus0.ack_o, bus0.err_o, bus0.data_o};
            obs3 = {bus3.ack_o, bus3.err_o, bus3.data_o};
            checks++;
            if (obs0 !== 34'h0) begin
                errors++;
                $display("FAIL reset_idle_ws0 cycle %0d: got %h expected %h", i, obs0, 34'h0);
            end
            checks++;
            if (obs3 !== 34'h0) begin
                errors++;
                $display("FAIL reset_idle_ws3 cycle %0d: got %h expected %h", i, obs3, 34'h0);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic err; logic wok;
        @(negedge clk);
        xact(0, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++;
        if (wok !== 1'b1) begin errors++; $display("FAIL wr_ack_width: got %b expected 1", wok); end
        xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++;
        if (wok !== 1'b1) begin errors++; $display("FAIL rd_ack_width: got %b expected 1", wok); end
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rd_data: got %h expected %h", rd, 32'h1122_3344); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err); end
    endtask

    task automatic test_masked_write();
        int lat; logic [31:0] rd; logic err; logic wok;
        @(negedge clk);
        xact(0, 1'b1, 32'h10, 4'b0100, 32'hAABB_CCDD, -1, lat, rd, err, wok);
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL mask_prewrite_data: got %h expected %h", rd, 32'h1122_3344); end
        xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (rd !== 32'h11BB_3344) begin errors++; $display("FAIL mask_rd_data: got %h expected %h", rd, 32'h11BB_3344); end
        xact(0, 1'b1, 32'h12, 4'b0000, 32'hFFFF_FFFF, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL mask0_latency: got %0d expected 2", lat); end
        xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (rd !== 32'h11BB_3344) begin errors++; $display("FAIL mask0_rd_data: got %h expected %h", rd, 32'h11BB_3344); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [31:0] rd1, rd2; logic err; logic wok;
        time t0;
        @(negedge clk);
        t0 = $time;
        xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, -1, lat1, rd1, err, wok);
        xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, -1, lat2, rd2, err, wok);
        // ack at cycles 2 and 5, return one cycle after the second ack
        checks++;
        if (($time - t0) !== 64'd60) begin errors++; $display("FAIL b2b_elapsed: got %0t expected 60", $time - t0); end
        checks++;
        if (lat2 !== 2) begin errors++; $display("FAIL b2b_latency2: got %0d expected 2", lat2); end
        checks++;
        if ({rd1, rd2} !== {32'h11BB_3344, 32'h11BB_3344}) begin
            errors++; $display("FAIL b2b_data: got %h %h expected 11bb3344 11bb3344", rd1, rd2);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] rd; logic err; logic wok;
        @(negedge clk);
        xact(3, 1'b1, 32'h4, 4'b1111, 32'h0102_0304, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL ws3_wr_latency: got %0d expected 5", lat); end
        xact(3, 1'b0, 32'h4, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL ws3_rd_latency: got %0d expected 5", lat); end
        checks++;
        if (wok !== 1'b1) begin errors++; $display("FAIL ws3_ack_width: got %b expected 1", wok); end
        checks++;
        if (rd !== 32'h0102_0304) begin errors++; $display("FAIL ws3_rd_data: got %h expected %h", rd, 32'h0102_0304); end
        xact(3, 1'b0, 32'h4, 4'b0000, 32'h0, 2, lat, rd, err, wok);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL ws3_drop_latency: got %0d expected 5", lat); end
        checks++;
        if (rd !== 32'h0102_0304) begin errors++; $display("FAIL ws3_drop_data: got %h expected %h", rd, 32'h0102_0304); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err; logic wok;
        logic saw_ack;
        @(negedge clk);
        xact(3, 1'b1, 32'h20, 4'b1111, 32'h1234_5678, -1, lat, rd, err, wok);
        drive(3, 1'b1, 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D);
        saw_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            saw_ack = saw_ack | bus3.ack_o;
        end
        rst3_n = 1'b0;
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (bus3.data_o !== 32'h0) begin errors++; $display("FAIL midrst_data_cleared: got %h expected 0", bus3.data_o); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) rst3_n = 1'b1;
            saw_ack = saw_ack | bus3.ack_o;
        end
        checks++;
        if (saw_ack !== 1'b0) begin errors++; $display("FAIL midrst_no_ack: got %b expected 0", saw_ack); end
        xact(3, 1'b0, 32'h20, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (rd !== 32'h1234_5678) begin errors++; $display("FAIL midrst_old_value: got %h expected %h", rd, 32'h1234_5678); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic err; logic wok;
        logic [31:0] exp_wr_data, exp_word0;
        logic        exp_err;
`ifdef BUS_RAM_RANGE_CHECK_EN
        exp_wr_data = 32'hDEAD_BEEF; exp_err = 1'b1; exp_word0 = 32'h0A0B_0C0D;
`else
        exp_wr_data = 32'h0A0B_0C0D; exp_err = 1'b0; exp_word0 = 32'h5566_7788;
`endif
        @(negedge clk);
        xact(0, 1'b1, 32'h0, 4'b1111, 32'h0A0B_0C0D, -1, lat, rd, err, wok);
        xact(0, 1'b1, 32'h4000, 4'b1111, 32'h5566_7788, -1, lat, rd, err, wok);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL range_latency: got %0d expected 2", lat); end
        checks++;
        if (err !== exp_err) begin errors++; $display("FAIL range_err: got %b expected %b", err, exp_err); end
        checks++;
        if (rd !== exp_wr_data) begin errors++; $display("FAIL range_data: got %h expected %h", rd, exp_wr_data); end
        checks++;
        if (bus0.err_o !== 1'b0) begin errors++; $display("FAIL range_err_after_ack: got %b expected 0", bus0.err_o); end
        xact(0, 1'b0, 32'h0, 4'b0000, 32'h0, -1, lat, rd, err, wok);
        checks++;
        if (rd !== exp_word0) begin errors++; $display("FAIL range_word0: got %h expected %h", rd, exp_word0); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL range_word0_err: got %b expected 0", err); end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
